pipelined_cla_adder: RTL

- Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath. Successor to the single-bit full_adder cell.
- Splits a WIDTH-bit add into CHUNK-bit carry-lookahead slices, one slice per pipeline stage, with the carry registered between stages.
- Accepts one operation per cycle; latency is WIDTH/CHUNK cycles.
- Outputs sum, carry-out, signed overflow and zero flags, qualified by a valid bit. Supports a global stall.

---
 rtl/pipelined_cla_adder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// pipelined_cla_adder -- WIDTH-bit add/sub built from CHUNK-bit CLA slices, one per pipeline stage.
// Rev 1.0
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NUM_STAGES = WIDTH / CHUNK;

  // Every carry is a flat sum-of-products of generate/propagate terms; nothing ripples.
  function automatic logic [CHUNK:0] cla_carries(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             c0
  );
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;
    logic             term;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = c0;
    for (int i = 1; i <= CHUNK; i++) begin
      term = c0;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

  logic [WIDTH-1:0] w_bop;
  logic             w_c0;
  logic             r_out_v;
  logic             r_out_c;
  logic             r_out_cmsb;
  logic             r_out_zero;
  logic [WIDTH-1:0] r_out_s;

  assign w_bop = sub ? ~B : B;
  assign w_c0  = sub | cin;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int IN_W = (NUM_STAGES - k) * CHUNK;
    localparam int LO_W = (k + 1) * CHUNK;

    logic [IN_W-1:0]  w_a_in;
    logic [IN_W-1:0]  w_b_in;
    logic             w_v_in;
    logic             w_c_in;
    logic [CHUNK:0]   w_carry;
    logic [CHUNK-1:0] w_sum;
    logic [LO_W-1:0]  w_s_acc;

    if (k == 0) begin : g_head
      assign w_a_in  = A;
      assign w_b_in  = w_bop;
      assign w_v_in  = in_valid;
      assign w_c_in  = w_c0;
      assign w_s_acc = w_sum;
    end else begin : g_tail
      // Operand skew shrinks by one chunk per stage while the finished sum grows by one.
      assign w_a_in  = g_stage[k-1].g_mid.r_a_rest;
      assign w_b_in  = g_stage[k-1].g_mid.r_b_rest;
      assign w_v_in  = g_stage[k-1].g_mid.r_v;
      assign w_c_in  = g_stage[k-1].g_mid.r_c;
      assign w_s_acc = {w_sum, g_stage[k-1].g_mid.r_s};
    end

    assign w_carry = cla_carries(w_a_in[CHUNK-1:0], w_b_in[CHUNK-1:0], w_c_in);
    assign w_sum   = w_a_in[CHUNK-1:0] ^ w_b_in[CHUNK-1:0] ^ w_carry[CHUNK-1:0];

    if (k < NUM_STAGES - 1) begin : g_mid
      logic                  r_v;
      logic                  r_c;
      logic [LO_W-1:0]       r_s;
      logic [IN_W-CHUNK-1:0] r_a_rest;
      logic [IN_W-CHUNK-1:0] r_b_rest;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_v      <= 1'b0;
          r_c      <= 1'b0;
          r_s      <= '0;
          r_a_rest <= '0;
          r_b_rest <= '0;
        end else if (!stall) begin
          r_v      <= w_v_in;
          r_c      <= w_carry[CHUNK];
          r_s      <= w_s_acc;
          r_a_rest <= w_a_in[IN_W-1:CHUNK];
          r_b_rest <= w_b_in[IN_W-1:CHUNK];
        end
      end
    end else begin : g_last
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_out_v    <= 1'b0;
          r_out_c    <= 1'b0;
          r_out_cmsb <= 1'b0;
          r_out_s    <= '0;
          r_out_zero <= 1'b0;
        end else if (!stall) begin
          r_out_v    <= w_v_in;
          r_out_c    <= w_carry[CHUNK];
          r_out_cmsb <= w_carry[CHUNK-1];
          r_out_s    <= w_s_acc;
          r_out_zero <= ~|w_s_acc;
        end
      end
    end
  end

  assign out_valid = r_out_v;
  assign S         = r_out_v ? r_out_s : '0;
  assign cout      = r_out_v & r_out_c;
  assign overflow  = r_out_v & (r_out_c ^ r_out_cmsb);
  assign zero      = r_out_v & r_out_zero;

endmodule
`default_nettype wire
